// File: rtl/key_event_scheduler.sv
// Key event scheduler: captures debounced press/release pulses, arbitrates them round-robin
// into an event FIFO and tracks the monophonic note. Optional sustain pedal: define SUSTAIN_EN.
module key_event_scheduler #(
    parameter int N_KEYS     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int KW         = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_press,
    input  logic [N_KEYS-1:0] key_release,
`ifdef SUSTAIN_EN
    input  logic              sustain,
`endif
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [KW-1:0]     evt_key,
    output logic              evt_press,
    output logic              note_active,
    output logic [KW-1:0]     note_idx,
    output logic [N_KEYS-1:0] held,
    output logic              drop_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [N_KEYS-1:0] pend_p, pend_r;
    logic [KW-1:0]     rr_ptr;
    logic [KW:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [KW-1:0]     last_key;
    logic              last_press;

    logic              gnt, gnt_press, pop, can_push;
    logic [KW-1:0]     gnt_key, idx;
    logic [N_KEYS-1:0] onehot, clr_p, clr_r, held_nxt;
    logic              note_active_nxt, sus_on, sus_fall;
    logic [KW-1:0]     note_idx_nxt;
    int                j;

    function automatic logic [KW-1:0] lowest(input logic [N_KEYS-1:0] v);
        lowest = '0;
        for (int i = N_KEYS - 1; i >= 0; i--)
            if (v[i]) lowest = KW'(i);
    endfunction

    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign can_push  = (count != CW'(FIFO_DEPTH)) || pop;
    assign evt_key   = evt_valid ? mem[rd_ptr][KW:1] : last_key;
    assign evt_press = evt_valid ? mem[rd_ptr][0]    : last_press;

    always_comb begin
        gnt       = 1'b0;
        gnt_key   = '0;
        gnt_press = 1'b0;
        j         = 0;
        idx       = '0;
        for (int off = 0; off < N_KEYS; off++) begin
            j = int'(rr_ptr) + off;
            if (j >= N_KEYS) j = j - N_KEYS;
            idx = KW'(j);
            if (!gnt && (pend_p[idx] || pend_r[idx])) begin
                gnt       = 1'b1;
                gnt_key   = idx;
                gnt_press = pend_p[idx];
            end
        end
        if (!can_push) gnt = 1'b0;
    end

    assign onehot   = N_KEYS'(1) << gnt_key;
    assign clr_p    = (gnt && gnt_press)  ? onehot : '0;
    assign clr_r    = (gnt && !gnt_press) ? onehot : '0;
    assign held_nxt = !gnt ? held : (gnt_press ? (held | onehot) : (held & ~onehot));

`ifdef SUSTAIN_EN
    logic sus_q, sus_fall_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sus_q      <= 1'b0;
            sus_fall_q <= 1'b0;
        end else begin
            sus_q      <= sustain;
            sus_fall_q <= sus_q && !sustain;
        end
    end
    assign sus_on   = sustain;
    assign sus_fall = sus_fall_q;
`else
    assign sus_on   = 1'b0;
    assign sus_fall = 1'b0;
`endif

    always_comb begin
        note_active_nxt = note_active;
        note_idx_nxt    = note_idx;
        if (sus_fall) begin
            if (held_nxt == '0) note_active_nxt = 1'b0;
            else                note_idx_nxt    = lowest(held_nxt);
        end
        if (gnt && !gnt_press && !sus_on && (gnt_key == note_idx)) begin
            if (held_nxt != '0) note_idx_nxt    = lowest(held_nxt);
            else                note_active_nxt = 1'b0;
        end
        if (gnt && gnt_press) begin
            note_idx_nxt    = gnt_key;
            note_active_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_p      <= '0;
            pend_r      <= '0;
            rr_ptr      <= '0;
            held        <= '0;
            note_idx    <= '0;
            note_active <= 1'b0;
            drop_err    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            last_key    <= '0;
            last_press  <= 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
        end else begin
            // A pulse landing on the bit being granted re-arms it rather than counting as a drop.
            pend_p <= (pend_p & ~clr_p) | key_press;
            pend_r <= (pend_r & ~clr_r) | key_release;
            if (|(key_press & pend_p & ~clr_p) || |(key_release & pend_r & ~clr_r))
                drop_err <= 1'b1;
            held        <= held_nxt;
            note_idx    <= note_idx_nxt;
            note_active <= note_active_nxt;
            if (gnt) begin
                mem[wr_ptr] <= {gnt_key, gnt_press};
                wr_ptr      <= wr_ptr + AW'(1);
                rr_ptr      <= (gnt_key == KW'(N_KEYS - 1)) ? '0 : gnt_key + KW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                last_key   <= mem[rd_ptr][KW:1];
                last_press <= mem[rd_ptr][0];
            end
            if (gnt && !pop)      count <= count + CW'(1);
            else if (!gnt && pop) count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler (N_KEYS=8, FIFO_DEPTH=4); sustain steps run when SUSTAIN_EN is defined.
module tb_key_event_scheduler;
    logic       clk;
    logic       rst;
    logic [7:0] kp, kr;
    logic       sus;
    logic       ready;
    logic       evt_valid, evt_press, note_active, drop_err;
    logic [2:0] evt_key, note_idx;
    logic [7:0] held;
    int         total, bad;
    logic [7:0] exp_seq [6];

    key_event_scheduler #(.N_KEYS(8), .FIFO_DEPTH(4), .KW(3)) dut (
        .clk(clk),
        .rst(rst),
        .key_press(kp),
        .key_release(kr),
`ifdef SUSTAIN_EN
        .sustain(sus),
`endif
        .evt_valid(evt_valid),
        .evt_ready(ready),
        .evt_key(evt_key),
        .evt_press(evt_press),
        .note_active(note_active),
        .note_idx(note_idx),
        .held(held),
        .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        kp = '0; kr = '0; sus = 1'b0; ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        tick(); tick();
        chk("rst_valid", 8'(evt_valid), 8'h0);
        chk("rst_note_active", 8'(note_active), 8'h0);
        chk("rst_held", held, 8'h00);
        chk("rst_drop", 8'(drop_err), 8'h0);
        chk("rst_key", 8'(evt_key), 8'h0);
        rst = 1'b1;
        tick();

        // single press latency
        kp = 8'h08; tick(); kp = '0;
        chk("p3_valid_early", 8'(evt_valid), 8'h0);
        tick();
        chk("p3_valid", 8'(evt_valid), 8'h1);
        chk("p3_key", 8'(evt_key), 8'h3);
        chk("p3_press", 8'(evt_press), 8'h1);
        chk("p3_note_active", 8'(note_active), 8'h1);
        chk("p3_note_idx", 8'(note_idx), 8'h3);
        chk("p3_held", held, 8'h08);

        // async reset mid-operation
        rst = 1'b0; #1;
        chk("mid_rst_valid", 8'(evt_valid), 8'h0);
        chk("mid_rst_note_active", 8'(note_active), 8'h0);
        chk("mid_rst_note_idx", 8'(note_idx), 8'h0);
        chk("mid_rst_held", held, 8'h00);
        chk("mid_rst_key", 8'(evt_key), 8'h0);
        tick(); rst = 1'b1; tick();

        // simultaneous presses 0 and 7
        ready = 1'b1;
        kp = 8'h81; tick(); kp = '0;
        tick();
        chk("sim_first_valid", 8'(evt_valid), 8'h1);
        chk("sim_first_key", 8'(evt_key), 8'h0);
        chk("sim_first_note", 8'(note_idx), 8'h0);
        tick();
        chk("sim_second_valid", 8'(evt_valid), 8'h1);
        chk("sim_second_key", 8'(evt_key), 8'h7);
        tick();
        chk("sim_empty_valid", 8'(evt_valid), 8'h0);
        chk("sim_hold_key", 8'(evt_key), 8'h7);
        chk("sim_note_idx", 8'(note_idx), 8'h7);
        chk("sim_held", held, 8'h81);

        kr = 8'h81; tick(); kr = '0;
        tick();
        chk("rel_nonsounding_note", 8'(note_idx), 8'h7);
        chk("rel_nonsounding_held", held, 8'h80);
        tick();
        chk("rel7_key", 8'(evt_key), 8'h7);
        chk("rel7_press", 8'(evt_press), 8'h0);
        tick();
        chk("rel_all_held", held, 8'h00);
        chk("rel_all_active", 8'(note_active), 8'h0);
        chk("rel_all_valid", 8'(evt_valid), 8'h0);

        // fallback to lowest held key
        kp = 8'h04; tick(); kp = 8'h20; tick(); kp = '0; tick(); tick();
        chk("hold25_note", 8'(note_idx), 8'h5);
        chk("hold25_held", held, 8'h24);
        kr = 8'h20; tick(); kr = '0; tick();
        chk("fallback_note", 8'(note_idx), 8'h2);
        chk("fallback_active", 8'(note_active), 8'h1);
        chk("fallback_held", held, 8'h04);
        kr = 8'h04; tick(); kr = '0; tick();
        chk("off_active", 8'(note_active), 8'h0);
        chk("off_held", held, 8'h00);
        tick();
        chk("off_drained", 8'(evt_valid), 8'h0);

        // full FIFO with stall, then drain in round-robin order (rr_ptr=3)
        ready = 1'b0;
        kp = 8'hF3; tick(); kp = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("full_valid", 8'(evt_valid), 8'h1);
        chk("full_head", 8'(evt_key), 8'h4);
        chk("full_held", held, 8'hF0);
        chk("full_note", 8'(note_idx), 8'h7);
        chk("full_drop", 8'(drop_err), 8'h0);
        exp_seq[0] = 8'h4; exp_seq[1] = 8'h5; exp_seq[2] = 8'h6;
        exp_seq[3] = 8'h7; exp_seq[4] = 8'h0; exp_seq[5] = 8'h1;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("drain_valid_%0d", i), 8'(evt_valid), 8'h1);
            chk($sformatf("drain_key_%0d", i), 8'(evt_key), exp_seq[i]);
            tick();
        end
        chk("drain_empty", 8'(evt_valid), 8'h0);
        chk("drain_note", 8'(note_idx), 8'h1);
        chk("drain_held", held, 8'hF3);

        // repeat press on a pending key (rr_ptr=2)
        ready = 1'b0;
        kp = 8'h1F; tick(); kp = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_head", 8'(evt_key), 8'h2);
        chk("stall_drop", 8'(drop_err), 8'h0);
        kp = 8'h02; tick(); kp = '0;
        chk("drop_set", 8'(drop_err), 8'h1);
        tick();
        chk("drop_sticky", 8'(drop_err), 8'h1);

        rst = 1'b0; #1;
        chk("end_rst_drop", 8'(drop_err), 8'h0);
        chk("end_rst_valid", 8'(evt_valid), 8'h0);
        chk("end_rst_held", held, 8'h00);
        tick(); rst = 1'b1; tick();

`ifdef SUSTAIN_EN
        ready = 1'b1;
        sus = 1'b1;
        kp = 8'h10; tick(); kp = '0; tick();
        chk("sus_press_note", 8'(note_idx), 8'h4);
        kr = 8'h10; tick(); kr = '0; tick();
        chk("sus_hold_active", 8'(note_active), 8'h1);
        chk("sus_hold_held", held, 8'h00);
        sus = 1'b0; tick(); tick();
        chk("sus_off_active", 8'(note_active), 8'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
